// File: rtl/decoder_pkg.sv
// Shared definitions for the registered one-hot decoder: mode encodings,
// the one-hot expansion and the dwell counter width helper.
package decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // onehot() is sized for the widest supported select; callers cast the
  // result down to their own 2^N width. Supports N up to ONEHOT_MAX_N.
  localparam int ONEHOT_MAX_N = 10;
  localparam int ONEHOT_MAX_W = 1 << ONEHOT_MAX_N;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [ONEHOT_MAX_N-1:0] code);
    logic [ONEHOT_MAX_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

  // max(1, clog2(hold)) so that HOLD=1 still gets a one-bit counter
  function automatic int dwell_w(input int hold);
    return (hold <= 2) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/decoder_scan_dwell_timer.sv
// Dwell counter: counts 0..HOLD-1 while run is high and pulses tick on the
// last count, wrapping back to 0 on that same edge.
module dwell_timer
  import decoder_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int             W    = dwell_w(HOLD);
  localparam logic [W-1:0]   LAST = W'(HOLD - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tick = run && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (run) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with a direct mode (decode sel) and a
// scan mode that strobes every output in turn for HOLD cycles each.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int N    = 2,
  parameter int HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      sel,
  output logic [(1<<N)-1:0] out,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int OUT_W = 1 << N;

  logic [N-1:0]     idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             scan_active_q, scan_active_d;

  logic             timer_run;
  logic             timer_clr;
  logic             tick;
  logic [N-1:0]     idx_inc;
  logic [OUT_W-1:0] sel_onehot;
  logic [OUT_W-1:0] inc_onehot;

  // The dwell timer only runs once a scan is established; any other
  // condition (disable, direct mode, scan entry) restarts the dwell.
  assign timer_run = en && (mode_e'(mode) == MODE_SCAN) && scan_active_q;
  assign timer_clr = !timer_run;

  assign idx_inc    = idx_q + 1'b1;
  assign sel_onehot = OUT_W'(onehot(ONEHOT_MAX_N'(sel)));
  assign inc_onehot = OUT_W'(onehot(ONEHOT_MAX_N'(idx_inc)));

  dwell_timer #(
    .HOLD (HOLD)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .run  (timer_run),
    .tick (tick)
  );

  always_comb begin
    idx_d         = idx_q;
    out_d         = out_q;
    wrap_d        = 1'b0;
    scan_active_d = 1'b0;
    if (!en) begin
      out_d = '0;
    end else if (mode_e'(mode) == MODE_DIRECT) begin
      idx_d = sel;
      out_d = sel_onehot;
    end else if (!scan_active_q) begin
      idx_d         = sel;
      out_d         = sel_onehot;
      scan_active_d = 1'b1;
    end else begin
      scan_active_d = 1'b1;
      if (tick) begin
        idx_d  = idx_inc;
        out_d  = inc_onehot;
        wrap_d = (idx_q == {N{1'b1}});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      out_q         <= '0;
      wrap_q        <= 1'b0;
      scan_active_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      out_q         <= out_d;
      wrap_q        <= wrap_d;
      scan_active_q <= scan_active_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: an N=2/HOLD=4 instance and an N=3/HOLD=1
// instance, outputs checked 1 time unit after each rising edge.
module tb_decoder_scan;

  logic       clk;
  logic       rst_a, en_a, mode_a;
  logic [1:0] sel_a;
  logic [3:0] out_a;
  logic [1:0] idx_a;
  logic       wrap_a;

  logic       rst_b, en_b, mode_b;
  logic [2:0] sel_b;
  logic [7:0] out_b;
  logic [2:0] idx_b;
  logic       wrap_b;

  int n_assert = 0;
  int n_fail   = 0;

  decoder_scan #(.N(2), .HOLD(4)) dut_a (
    .clk (clk), .rst (rst_a), .en (en_a), .mode (mode_a), .sel (sel_a),
    .out (out_a), .idx (idx_a), .wrap (wrap_a)
  );

  decoder_scan #(.N(3), .HOLD(1)) dut_b (
    .clk (clk), .rst (rst_b), .en (en_b), .mode (mode_b), .sel (sel_b),
    .out (out_b), .idx (idx_b), .wrap (wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] e_out, input logic [1:0] e_idx,
                       input logic e_wrap);
    $display("A %s: out=%b idx=%0d wrap=%b", tag, out_a, idx_a, wrap_a);
    chk({tag, ".out"}, 32'(out_a), 32'(e_out));
    chk({tag, ".idx"}, 32'(idx_a), 32'(e_idx));
    chk({tag, ".wrap"}, 32'(wrap_a), 32'(e_wrap));
  endtask

  task automatic chk_b(input string tag, input logic [7:0] e_out, input logic [2:0] e_idx,
                       input logic e_wrap);
    $display("B %s: out=%b idx=%0d wrap=%b", tag, out_b, idx_b, wrap_b);
    chk({tag, ".out"}, 32'(out_b), 32'(e_out));
    chk({tag, ".idx"}, 32'(idx_b), 32'(e_idx));
    chk({tag, ".wrap"}, 32'(wrap_b), 32'(e_wrap));
  endtask

  logic [3:0] exp_dir  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] exp_scan [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [1:0] exp_sidx [4] = '{2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    rst_a = 1'b1; en_a = 1'b1; mode_a = 1'b1; sel_a = 2'd3;
    rst_b = 1'b1; en_b = 1'b0; mode_b = 1'b0; sel_b = 3'd0;

    // reset held two cycles with scan requested
    step(); chk_a("rst0", 4'b0000, 2'd0, 1'b0);
    step(); chk_a("rst1", 4'b0000, 2'd0, 1'b0);
    rst_a = 1'b0;
    #1; chk_a("post_rst", 4'b0000, 2'd0, 1'b0);
    step(); chk_a("rst_scan_entry", 4'b1000, 2'd3, 1'b0);

    // direct sweep
    mode_a = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s);
      step(); chk_a($sformatf("direct%0d", s), exp_dir[s], 2'(s), 1'b0);
    end

    // enable gating
    sel_a = 2'd2;
    step(); chk_a("gate_pre", 4'b0100, 2'd2, 1'b0);
    en_a = 1'b0; sel_a = 2'd1;
    for (int k = 0; k < 3; k++) begin
      step(); chk_a($sformatf("gate_off%0d", k), 4'b0000, 2'd2, 1'b0);
    end
    en_a = 1'b1; sel_a = 2'd2;
    step(); chk_a("gate_on", 4'b0100, 2'd2, 1'b0);

    // scan from 2 through a wrap; sel changed mid-scan has no effect
    mode_a = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 2) sel_a = 2'd0;
      step(); chk_a($sformatf("scan%0d", k), exp_scan[k/4], exp_sidx[k/4], (k == 8));
    end
    step(); chk_a("scan16", 4'b0100, 2'd2, 1'b0);
    step(); chk_a("scan17", 4'b0100, 2'd2, 1'b0);

    // mid-dwell switch to direct, then back to scan from sel
    mode_a = 1'b0; sel_a = 2'd1;
    step(); chk_a("to_direct", 4'b0010, 2'd1, 1'b0);
    mode_a = 1'b1; sel_a = 2'd3;
    for (int k = 0; k < 4; k++) begin
      step(); chk_a($sformatf("reentry%0d", k), 4'b1000, 2'd3, 1'b0);
    end
    step(); chk_a("reentry_wrap", 4'b0001, 2'd0, 1'b1);
    step(); chk_a("reentry_after", 4'b0001, 2'd0, 1'b0);
    en_a = 1'b0;

    // N=3, HOLD=1: one code per cycle
    rst_b = 1'b0; en_b = 1'b1; mode_b = 1'b1; sel_b = 3'd6;
    step(); chk_b("b_entry", 8'h40, 3'd6, 1'b0);
    sel_b = 3'd1;
    step(); chk_b("b_7", 8'h80, 3'd7, 1'b0);
    step(); chk_b("b_0", 8'h01, 3'd0, 1'b1);
    step(); chk_b("b_1", 8'h02, 3'd1, 1'b0);
    step(); chk_b("b_2", 8'h04, 3'd2, 1'b0);
    rst_b = 1'b1;
    step(); chk_b("b_rst", 8'h00, 3'd0, 1'b0);
    rst_b = 1'b0; sel_b = 3'd6;
    step(); chk_b("b_restart", 8'h40, 3'd6, 1'b0);
    step(); chk_b("b_restart7", 8'h80, 3'd7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
